// File: rtl/seg7_anim_pkg.sv
// Shared types and default timing constants for the seg7 animation playback path.
//
// Contents:
//   sched_state_e  - playback FSM state; bit 1 = auto mode, bit 0 = paused
//   ANI_MAX        - highest animation index
//   PERIOD_*       - frame period defaults in clk cycles
package seg7_anim_pkg;

    // The encoding is load-bearing: mode and pause toggles are applied by XOR-ing
    // the button pulses onto these two bits.
    typedef enum logic [1:0] {
        MAN_RUN    = 2'b00,
        MAN_PAUSE  = 2'b01,
        AUTO_RUN   = 2'b10,
        AUTO_PAUSE = 2'b11
    } sched_state_e;

    localparam int unsigned ANI_MAX     = 33;
    localparam int unsigned PERIOD_RST  = 10_000_000;
    localparam int unsigned PERIOD_MIN  = 1_000_000;
    localparam int unsigned PERIOD_MAX  = 19_000_000;
    localparam int unsigned PERIOD_STEP = 1_000_000;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame period timer: holds the adjustable frame period and a free-running
// counter, and emits an advance strobe once per period while running.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ena         - global enable; low freezes period and counter, strobe forced low
//   run         - count only while high (playback not paused)
//   slower      - pulse: period += PERIOD_STEP if the result stays <= PERIOD_MAX
//   faster      - pulse: period -= PERIOD_STEP if the result stays >= PERIOD_MIN
//   clear       - restart the period (counter to 0), wins over counting
//   strobe      - combinational advance strobe, high when the period elapses
module frame_tick_gen #(
    parameter int unsigned CNT_BIT     = 25,
    parameter int unsigned PERIOD_RST  = seg7_anim_pkg::PERIOD_RST,
    parameter int unsigned PERIOD_MIN  = seg7_anim_pkg::PERIOD_MIN,
    parameter int unsigned PERIOD_MAX  = seg7_anim_pkg::PERIOD_MAX,
    parameter int unsigned PERIOD_STEP = seg7_anim_pkg::PERIOD_STEP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic run,
    input  logic slower,
    input  logic faster,
    input  logic clear,
    output logic strobe
);
    import seg7_anim_pkg::*;

    localparam int unsigned WideBit = CNT_BIT + 1;

    // Period arithmetic is done one bit wider so the +STEP sum cannot wrap.
    localparam logic [CNT_BIT:0]   StepW = WideBit'(PERIOD_STEP);
    localparam logic [CNT_BIT:0]   MinW  = WideBit'(PERIOD_MIN);
    localparam logic [CNT_BIT:0]   MaxW  = WideBit'(PERIOD_MAX);
    localparam logic [CNT_BIT:0]   OneW  = WideBit'(1);
    localparam logic [CNT_BIT-1:0] RstV  = CNT_BIT'(PERIOD_RST);

    logic [CNT_BIT-1:0] period_q, period_d;
    logic [CNT_BIT-1:0] counter_q, counter_d;
    logic [CNT_BIT:0]   period_w, period_up;
    logic               at_end;

    always_comb begin
        period_w  = {1'b0, period_q};
        period_up = period_w + StepW;
        period_d  = period_q;
        // Simultaneous slower+faster cancel out.
        if (slower && !faster && (period_up <= MaxW)) begin
            period_d = period_up[CNT_BIT-1:0];
        end else if (faster && !slower && (period_w >= MinW + StepW)) begin
            period_d = period_q - StepW[CNT_BIT-1:0];
        end

        // >= rather than == so a period shrunk below the current count fires at once.
        at_end = ({1'b0, counter_q} >= (period_w - OneW));
        strobe = ena && run && at_end;

        counter_d = counter_q;
        if (clear) begin
            counter_d = '0;
        end else if (run) begin
            counter_d = at_end ? '0 : counter_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= RstV;
            counter_q <= '0;
        end else if (ena) begin
            period_q  <= period_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: rtl/seg7_anim_scheduler.sv
// Playback controller for the seven-segment animation datapath. Owns the
// playback FSM (manual/auto x run/pause), frame index, loop counter and
// animation index; the frame period timer lives in frame_tick_gen.
//
// Build option: define SCHED_PINGPONG_EN to make auto advance bounce between
// 0 and ANI_MAX instead of wrapping; manual select always wraps.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - global enable; low freezes all state and ignores pulses
//   btn_next     - pulse: animation + 1 (wraps ANI_MAX -> 0)
//   btn_prev     - pulse: animation - 1 (wraps 0 -> ANI_MAX)
//   btn_slower   - pulse: lengthen frame period
//   btn_faster   - pulse: shorten frame period
//   btn_mode     - pulse: toggle manual/auto
//   btn_pause    - pulse: toggle run/pause
//   frame_limit  - last valid frame index of the current animation
//   animation    - current animation index
//   frame        - current frame index
//   frame_tick   - one-cycle pulse alongside each new frame value
//   auto_mode    - high in auto states
//   paused       - high in pause states
module seg7_anim_scheduler #(
    parameter int unsigned ANI_BIT       = 6,
    parameter int unsigned ANI_MAX       = seg7_anim_pkg::ANI_MAX,
    parameter int unsigned CNT_BIT       = 25,
    parameter int unsigned PERIOD_RST    = seg7_anim_pkg::PERIOD_RST,
    parameter int unsigned PERIOD_MIN    = seg7_anim_pkg::PERIOD_MIN,
    parameter int unsigned PERIOD_MAX    = seg7_anim_pkg::PERIOD_MAX,
    parameter int unsigned PERIOD_STEP   = seg7_anim_pkg::PERIOD_STEP,
    parameter int unsigned LOOPS_PER_ANI = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               btn_slower,
    input  logic               btn_faster,
    input  logic               btn_mode,
    input  logic               btn_pause,
    input  logic [ANI_BIT-1:0] frame_limit,
    output logic [ANI_BIT-1:0] animation,
    output logic [ANI_BIT-1:0] frame,
    output logic               frame_tick,
    output logic               auto_mode,
    output logic               paused
);
    import seg7_anim_pkg::*;

    localparam int unsigned LoopBit = (LOOPS_PER_ANI > 1) ? $clog2(LOOPS_PER_ANI) : 1;
    localparam logic [LoopBit-1:0] LoopLast = LoopBit'(LOOPS_PER_ANI - 1);
    localparam logic [ANI_BIT-1:0] AniMax   = ANI_BIT'(ANI_MAX);
    localparam logic [ANI_BIT-1:0] AniOne   = ANI_BIT'(1);

    sched_state_e       state_q, state_d;
    logic [ANI_BIT-1:0] ani_q, ani_d, ani_auto;
    logic [ANI_BIT-1:0] frame_q, frame_d;
    logic [LoopBit-1:0] loop_q, loop_d;
    logic               frame_tick_q, auto_mode_q, paused_q;
    logic               auto_d, paused_d;
    logic               is_auto, is_run, mode_p, pause_p, next_p, prev_p;
    logic               enter_auto, strobe, wrap, auto_step, manual_sel, ani_change;

    // Pulses are ignored while disabled.
    assign mode_p  = ena && btn_mode;
    assign pause_p = ena && btn_pause;
    assign next_p  = ena && btn_next && !btn_prev;
    assign prev_p  = ena && btn_prev && !btn_next;

    assign is_auto = (state_q == AUTO_RUN) || (state_q == AUTO_PAUSE);
    assign is_run  = (state_q == MAN_RUN) || (state_q == AUTO_RUN);

    frame_tick_gen #(
        .CNT_BIT     (CNT_BIT),
        .PERIOD_RST  (PERIOD_RST),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_MAX  (PERIOD_MAX),
        .PERIOD_STEP (PERIOD_STEP)
    ) u_frame_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .run    (is_run),
        .slower (btn_slower),
        .faster (btn_faster),
        .clear  (ani_change),
        .strobe (strobe)
    );

    // FSM next state: the two toggles map directly onto the two state bits.
    always_comb begin
        state_d    = sched_state_e'(state_q ^ {mode_p, pause_p});
        enter_auto = mode_p && !is_auto;
        auto_d     = (state_d == AUTO_RUN) || (state_d == AUTO_PAUSE);
        paused_d   = (state_d == MAN_PAUSE) || (state_d == AUTO_PAUSE);
    end

`ifdef SCHED_PINGPONG_EN
    logic dir_q, dir_d, dir_auto;  // 0 = counting up, 1 = counting down

    always_comb begin
        dir_auto = dir_q;
        if (!dir_q) begin
            if (ani_q >= AniMax) begin
                ani_auto = AniMax - AniOne;
                dir_auto = 1'b1;
            end else begin
                ani_auto = ani_q + AniOne;
                dir_auto = (ani_auto == AniMax);
            end
        end else begin
            if (ani_q == '0) begin
                ani_auto = AniOne;
                dir_auto = 1'b0;
            end else begin
                ani_auto = ani_q - AniOne;
                dir_auto = (ani_auto != '0);
            end
        end
        dir_d = (auto_step && !manual_sel) ? dir_auto : dir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (ena) begin
            dir_q <= dir_d;
        end
    end
`else
    always_comb begin
        ani_auto = (ani_q >= AniMax) ? '0 : ani_q + AniOne;
    end
`endif

    // Frame, loop and animation select. Manual select overrides an auto step.
    always_comb begin
        wrap       = strobe && (frame_q >= frame_limit);
        auto_step  = is_auto && wrap && (loop_q == LoopLast);
        manual_sel = next_p || prev_p;
        ani_change = manual_sel || auto_step;

        ani_d = ani_q;
        if (next_p) begin
            ani_d = (ani_q >= AniMax) ? '0 : ani_q + AniOne;
        end else if (prev_p) begin
            ani_d = (ani_q == '0) ? AniMax : ani_q - AniOne;
        end else if (auto_step) begin
            ani_d = ani_auto;
        end

        frame_d = frame_q;
        if (ani_change) begin
            frame_d = '0;
        end else if (strobe) begin
            frame_d = wrap ? '0 : frame_q + AniOne;
        end

        loop_d = loop_q;
        if (ani_change || enter_auto) begin
            loop_d = '0;
        end else if (wrap) begin
            loop_d = loop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MAN_RUN;
            ani_q   <= '0;
            frame_q <= '0;
            loop_q  <= '0;
        end else if (ena) begin
            state_q <= state_d;
            ani_q   <= ani_d;
            frame_q <= frame_d;
            loop_q  <= loop_d;
        end
    end

    // Status outputs; strobe is already low while disabled, so frame_tick drops too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick_q <= 1'b0;
            auto_mode_q  <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            frame_tick_q <= strobe;
            auto_mode_q  <= auto_d;
            paused_q     <= paused_d;
        end
    end

    assign animation  = ani_q;
    assign frame      = frame_q;
    assign frame_tick = frame_tick_q;
    assign auto_mode  = auto_mode_q;
    assign paused     = paused_q;

endmodule

// File: doc/seg7_anim_scheduler.md
Name: seg7_anim_scheduler

Overview:
- Playback controller for the seven-segment animation datapath.
- Owns the frame-period timer, frame index, animation index and playback mode (manual/auto, run/pause).
- Sits between the button one-shot pulses and the seg7 decoder. Its outputs animation/frame drive the decoder; its frame_limit input comes from the per-animation limit lookup.
- In auto mode it advances to the next animation after a programmed number of complete loops.

Parameters:
- ANI_BIT, 6, width of animation and frame indices
- ANI_MAX, 33, highest animation index
- CNT_BIT, 25, period counter width
- PERIOD_RST, 10_000_000, frame period after reset, in clk cycles
- PERIOD_MIN, 1_000_000, smallest allowed period
- PERIOD_MAX, 19_000_000, largest allowed period
- PERIOD_STEP, 1_000_000, period change per speed pulse
- LOOPS_PER_ANI, 4, complete frame loops per animation in auto mode (≥1)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- ena, input, 1, global enable; low freezes all registers
- btn_next, input, 1, one-cycle pulse: next animation
- btn_prev, input, 1, one-cycle pulse: previous animation
- btn_slower, input, 1, one-cycle pulse: period += PERIOD_STEP
- btn_faster, input, 1, one-cycle pulse: period -= PERIOD_STEP
- btn_mode, input, 1, one-cycle pulse: toggle manual/auto
- btn_pause, input, 1, one-cycle pulse: toggle run/pause
- frame_limit, input, ANI_BIT, last valid frame index of the current animation
- animation, output, ANI_BIT, current animation index
- frame, output, ANI_BIT, current frame index
- frame_tick, output, 1, registered one-cycle pulse, high in the cycle after the frame register advances
- auto_mode, output, 1, high in AUTO_* states
- paused, output, 1, high in *_PAUSE states

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=MAN_RUN; animation=0, frame=0.
  - period=PERIOD_RST; counter=0; loop_cnt=0.
  - frame_tick=0, auto_mode=0, paused=0.
- ena=0: every register holds, frame_tick=0, pulses are ignored.
- FSM states: MAN_RUN, MAN_PAUSE, AUTO_RUN, AUTO_PAUSE.
  - btn_mode toggles MAN<->AUTO and keeps the run/pause half.
  - btn_pause toggles RUN<->PAUSE and keeps the mode half.
  - Both pulses in the same cycle apply both toggles (e.g. MAN_RUN -> AUTO_PAUSE).
  - Entering AUTO clears loop_cnt.
- Period timer:
  - In RUN states, counter increments each cycle.
  - When counter >= period-1, counter clears to 0 and an internal advance strobe fires.
  - In PAUSE states, counter holds and no strobe fires.
- Frame advance on strobe:
  - If frame >= frame_limit: frame=0 and loop_cnt increments.
  - Otherwise: frame+1.
  - The >= comparison lets a frame above a newly shrunk frame_limit recover on the next strobe.
- Auto advance: in AUTO_RUN, when the frame wraps and loop_cnt == LOOPS_PER_ANI-1, animation advances by one. Wrap is ANI_MAX->0.
- Manual select (valid in all four states):
  - btn_next: animation+1, wrapping ANI_MAX->0.
  - btn_prev: animation-1, wrapping 0->ANI_MAX.
  - btn_next and btn_prev together: no change.
- Any animation change (manual or auto) in cycle N gives, from cycle N+1: frame=0, counter=0, loop_cnt=0.
- Manual select and auto advance in the same cycle: the manual result is used; the auto step is discarded.
- Speed:
  - btn_slower: period += STEP only if period+STEP <= PERIOD_MAX; otherwise period holds.
  - btn_faster: period -= STEP only if period-STEP >= PERIOD_MIN; otherwise period holds.
  - Both pulses together: no change.
  - A period change does not clear counter. If counter >= new period-1, the strobe fires on the next cycle.
- Arithmetic: all compares are unsigned. Period sums are computed CNT_BIT+1 wide to avoid overflow.
- Output registration: frame_tick, auto_mode and paused are registered.

Optional Feature:
- Macro: SCHED_PINGPONG_EN.
- Defined:
  - Auto advance uses a direction register, which resets to up.
  - Going up, reaching ANI_MAX flips direction to down; the next auto step goes to ANI_MAX-1.
  - Going down, reaching 0 flips direction to up.
  - Manual btn_next/btn_prev ignore the direction register and keep wrap semantics.
- Undefined: auto advance always wraps ANI_MAX->0, and no direction register is built.

Decomposition:
- Package seg7_anim_pkg holds:
  - the state enum (MAN_RUN, MAN_PAUSE, AUTO_RUN, AUTO_PAUSE);
  - ANI_MAX;
  - the PERIOD_RST/MIN/MAX/STEP defaults.
- One sub-module, frame_tick_gen, contains period register, saturating speed update, counter and strobe. Inputs: run, ena, slower, faster, clear.
- FSM, frame/loop counters and animation select stay in the top level.

Test Plan:
Bench parameters: PERIOD_RST=10, STEP=2, MIN=2, MAX=18, LOOPS_PER_ANI=2, frame_limit=3.
- Reset, MAN_RUN, 40 cycles -> 4 frame_ticks, 10 cycles apart; frame steps 1,2,3,0; animation stays 0.
- btn_mode, then run 80 cycles -> AUTO_RUN; animation becomes 1 on the wrap that completes loop 2, at cycle 80.
- btn_prev at animation=0 -> animation=33, frame=0. btn_next and btn_prev together -> no change.
- btn_faster ×5 from period 10 -> period 8,6,4,2,2 (saturates). btn_slower ×9 -> period ends at 18.
- btn_pause mid-period at counter=5 for 30 cycles -> no frame_tick, counter stays 5. Second btn_pause -> first tick 5 cycles later.
- Pingpong build: auto-advance from animation 33 goes to 32; from 0 goes to 1. Async rst_n mid-period -> all outputs back to their reset values immediately.
